// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path: segment patterns
// (active-high, bit order {g,f,e,d,c,b,a}), digit index type and decoder.
package seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIGIT_FIRST = 2'd0;
    localparam digit_idx_t DIGIT_LAST  = 2'd3;

    // Non-decimal nibbles render as a dash so corrupt time words are visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD nibble to active-high segment pattern.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; blanking and polarity are handled by the scanner.
    always_comb begin
        seg_o = bcd_to_seg(bcd_i);
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode display scanner with per-frame snapshot,
// 8-level PWM dimming, field blinking, leading-zero blanking and a
// final-cycle anode guard against ghosting.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLINK_FRAMES = 62,
    parameter int unsigned LZ_BLANK     = 1,
    parameter int unsigned SEG_ACT_LOW  = 1,
    parameter int unsigned AN_ACT_LOW   = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] numbers,
    input  logic        blink_en,
    input  logic        blink_sel,
    input  logic [2:0]  brightness,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PH_LEN   = TICK_DIV / 8;
    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam int unsigned BW       = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(PH_LEN - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_IDLE = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_IDLE  = (SEG_ACT_LOW != 0);
    localparam logic [3:0] AN_IDLE  = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

    // Timing state
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] ph_cnt_q, ph_cnt_d;
    logic [2:0]    phase_q, phase_d;
    logic [2:0]    bright_q, bright_d;
    digit_idx_t    idx_q, idx_d;

    // Frame / blink state
    logic [15:0]   snap_q, snap_d;
    logic          started_q, started_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Registered pins
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          fs_q, fs_d;

    // Combinational helpers
    logic          tick;
    logic          ph_end;
    logic          wrap;
    logic [3:0]    digit_val;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_raw;
    logic          lz_blank;
    logic          in_field;
    logic          suppress;
    logic          an_on;
    logic [3:0]    an_raw;

    assign digit_val = snap_q[{idx_q, 2'b00} +: 4];

    seg_decoder u_dec (
        .bcd_i (digit_val),
        .seg_o (dec_seg)
    );

    // Prescaler, PWM phase, digit scan, snapshot and blink next-state.
    always_comb begin
        tick   = (presc_q == PRESC_LAST);
        ph_end = (ph_cnt_q == PH_LAST);
        wrap   = tick && (idx_q == DIGIT_LAST);

        presc_d  = tick ? '0 : presc_q + 1'b1;
        ph_cnt_d = (tick || ph_end) ? '0 : ph_cnt_q + 1'b1;

        phase_d = phase_q;
        if (tick) begin
            phase_d = '0;
        end else if (ph_end) begin
            phase_d = phase_q + 3'd1;
        end

        // Brightness is only re-sampled on phase boundaries so a change never
        // truncates or extends the phase already in progress.
        bright_d = ph_end ? brightness : bright_q;

        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        snap_d    = wrap ? numbers : snap_q;
        started_d = started_q | wrap;

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blink_en) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Output pattern for the current slot; polarity applied only here.
    always_comb begin
        lz_blank = (LZ_BLANK != 0) && (idx_q == DIGIT_LAST) && (digit_val == 4'd0);
        seg_raw  = lz_blank ? SEG_OFF : dec_seg;

        // Minutes field is digits 1,0 (idx[1]=0); hours field is digits 3,2.
        in_field = blink_sel ? ~idx_q[1] : idx_q[1];
        suppress = blink_en && blink_phase_q && in_field;

        an_on  = started_q && (phase_q <= bright_q) && !suppress && !tick;
        an_raw = an_on ? (4'b0001 << idx_q) : 4'b0000;

        seg_d = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
        dp_d  = (SEG_ACT_LOW != 0) ? ~dp_mask[idx_q] : dp_mask[idx_q];
        an_d  = (AN_ACT_LOW != 0) ? ~an_raw : an_raw;
        fs_d  = wrap;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc_q       <= '0;
            ph_cnt_q      <= '0;
            phase_q       <= '0;
            bright_q      <= '0;
            idx_q         <= DIGIT_LAST;
            snap_q        <= '0;
            started_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_IDLE;
            dp_q          <= DP_IDLE;
            an_q          <= AN_IDLE;
            fs_q          <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            ph_cnt_q      <= ph_cnt_d;
            phase_q       <= phase_d;
            bright_q      <= bright_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            started_q     <= started_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            fs_q          <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with TICK_DIV=16, BLINK_FRAMES=2,
// active-low segments and anodes. Time t counts clock edges since the
// most recent reset release; outputs are sampled 1 time unit after each edge.
module tb_seven_seg_scan;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] numbers;
    logic        blink_en;
    logic        blink_sel;
    logic [2:0]  brightness;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    seven_seg_scan #(
        .CLK_HZ       (1600),
        .SCAN_HZ      (100),
        .BLINK_FRAMES (2),
        .LZ_BLANK     (1),
        .SEG_ACT_LOW  (1),
        .AN_ACT_LOW   (1)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .numbers     (numbers),
        .blink_en    (blink_en),
        .blink_sel   (blink_sel),
        .brightness  (brightness),
        .dp_mask     (dp_mask),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          at;
        logic [3:0]  an;
        logic        chk_sd;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
        logic        set_num;
        logic [15:0] num;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic goto(input int target);
        total++;
        if (target < t) begin
            bad++;
            $display("FAIL goto: got t=%0d expected <= %0d", t, target);
        end
        while (t < target) step();
    endtask

    // Counts edges over one 16-cycle slot where an shows exactly pat;
    // any other lit pattern adds 100 so a wrong digit cannot hide.
    task automatic count_slot(input logic [3:0] pat, input int exp_n, input string name);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (an === pat) n++;
            else if (an !== 4'hF) n += 100;
        end
        chk(name, 16'(n), 16'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_N      = 1'b0;
        numbers    = 16'h1234;
        blink_en   = 1'b0;
        blink_sel  = 1'b0;
        brightness = 3'd7;
        dp_mask    = 4'b1100;

        //               at   an     sd    seg     dp    fs    set   num
        vecs.push_back('{16,  4'hF, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{17,  4'hE, 1'b1, 7'h19, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{32,  4'hF, 1'b1, 7'h19, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{33,  4'hD, 1'b1, 7'h30, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{40,  4'hD, 1'b1, 7'h30, 1'b1, 1'b0, 1'b1, 16'h5678});
        vecs.push_back('{49,  4'hB, 1'b1, 7'h24, 1'b0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{65,  4'h7, 1'b1, 7'h79, 1'b0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{80,  4'hF, 1'b1, 7'h79, 1'b0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{81,  4'hE, 1'b1, 7'h00, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{97,  4'hD, 1'b1, 7'h78, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{113, 4'hB, 1'b1, 7'h02, 1'b0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{129, 4'h7, 1'b1, 7'h12, 1'b0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{130, 4'h7, 1'b1, 7'h12, 1'b0, 1'b0, 1'b1, 16'h09A5});
        vecs.push_back('{144, 4'hF, 1'b1, 7'h12, 1'b0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{145, 4'hE, 1'b1, 7'h12, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{161, 4'hD, 1'b1, 7'h3F, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{177, 4'hB, 1'b1, 7'h10, 1'b0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{193, 4'h7, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0, 16'h0000});

        // Reset state
        repeat (5) @(posedge CLK);
        #1;
        chk("reset_an",  16'(an), 16'hF);
        chk("reset_seg", 16'(seg), 16'h7F);
        chk("reset_dp",  16'(dp), 16'h1);
        chk("reset_fs",  16'(frame_start), 16'h0);

        RST_N = 1'b1;
        t = 0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (an !== 4'hF) n++;
        end
        chk("dark_after_reset", 16'(n), 16'h0);

        // Scan, snapshot, blanking and decode vectors
        foreach (vecs[i]) begin
            goto(vecs[i].at);
            chk($sformatf("an@%0d", vecs[i].at), 16'(an), 16'(vecs[i].an));
            if (vecs[i].chk_sd) begin
                chk($sformatf("seg@%0d", vecs[i].at), 16'(seg), 16'(vecs[i].seg));
                chk($sformatf("dp@%0d", vecs[i].at), 16'(dp), 16'(vecs[i].dp));
            end
            chk($sformatf("fs@%0d", vecs[i].at), 16'(frame_start), 16'(vecs[i].fs));
            if (vecs[i].set_num) numbers = vecs[i].num;
        end

        // Brightness
        goto(200);
        brightness = 3'd0;
        goto(208);
        count_slot(4'hE, 2, "bright0_d0");
        brightness = 3'd7;
        count_slot(4'hD, 15, "bright7_d1");
        brightness = 3'd3;
        count_slot(4'hB, 8, "bright3_d2");
        brightness = 3'd7;
        blink_en   = 1'b1;
        blink_sel  = 1'b1;
        count_slot(4'h7, 15, "bright7_d3_blank");

        // Blink: minutes visible in frame 272, dark in frames 336 and 400
        count_slot(4'hE, 15, "blink_vis_d0");
        count_slot(4'hD, 15, "blink_vis_d1");
        goto(336);
        count_slot(4'hE, 0, "blink_dark_d0");
        count_slot(4'hD, 0, "blink_dark_d1");
        count_slot(4'hB, 15, "blink_hours_d2");
        count_slot(4'h7, 15, "blink_hours_d3");
        count_slot(4'hE, 0, "blink_dark2_d0");
        goto(420);
        blink_en = 1'b0;
        goto(422);
        chk("blink_drop_an", 16'(an), 16'hD);
        goto(432);
        count_slot(4'hB, 15, "after_drop_d2");
        goto(464);
        count_slot(4'hE, 15, "after_drop_d0");

        // Reset mid-operation during digit 2, phase 3
        goto(502);
        RST_N = 1'b0;
        step();
        chk("midrst_an", 16'(an), 16'hF);
        chk("midrst_fs", 16'(frame_start), 16'h0);
        numbers = 16'h4321;
        step();
        step();
        RST_N = 1'b1;
        t = 0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (an !== 4'hF) n++;
        end
        chk("midrst_dark", 16'(n), 16'h0);
        step();
        chk("midrst_fs_tick", 16'(frame_start), 16'h1);
        step();
        chk("midrst_d0_an",  16'(an), 16'hE);
        chk("midrst_d0_seg", 16'(seg), 16'h79);
        goto(33);
        chk("midrst_d1_an",  16'(an), 16'hD);
        chk("midrst_d1_seg", 16'(seg), 16'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Downstream display stage of the clock path; consumes the 16-bit packed BCD time word (HH:MM, digit 3 = hours tens … digit 0 = minutes units).
- Time-multiplexes a 4-digit common-anode seven-segment display.
- Adds tear-free per-frame snapshotting, 8-level brightness PWM, blinking of the field being edited, leading-zero blanking and invalid-BCD indication.

Parameters:
CLK_HZ, 100000000, system clock frequency
SCAN_HZ, 1000, digit slot rate; TICK_DIV = CLK_HZ/SCAN_HZ, must be a multiple of 8 and at least 8
BLINK_FRAMES, 62, frames per blink half-period (frame = 4 slots)
LZ_BLANK, 1, 1 = blank digit 3 when it is 0
SEG_ACT_LOW, 1, 1 = seg/dp outputs active-low
AN_ACT_LOW, 1, 1 = anode outputs active-low

Ports:
CLK  in  1  system clock, only clock
RST_N  in  1  reset, synchronous, active-low
numbers  in  16  packed BCD {H10,H1,M10,M1}
blink_en  in  1  1 = blink the field selected by blink_sel
blink_sel  in  1  0 = hours (digits 3,2), 1 = minutes (digits 1,0)
brightness  in  3  duty level; on-phases per slot = brightness+1
dp_mask  in  4  per-digit decimal point enable
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
an  out  4  digit anodes, bit i = digit i
frame_start  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Clocking and reset: one clock CLK; reset is synchronous and active-low on RST_N. All state updates on posedge CLK.
- Reset values:
  - prescaler = 0, phase = 0, digit_idx = 3, snapshot = 0, blink_cnt = 0, blink_phase = 0, started = 0.
  - Outputs: an all inactive, seg all inactive, dp inactive, frame_start = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick asserted when prescaler = TICK_DIV-1, then wraps to 0.
  - phase (0..7) advances every TICK_DIV/8 cycles and returns to 0 with tick.
- Digit scan: on tick, digit_idx increments mod 4 (3 -> 0).
- Wrap to 0 (including the first tick after reset, since digit_idx resets to 3):
  - snapshot <= numbers; started <= 1.
  - frame_start pulses in the same cycle that digit_idx becomes 0.
- numbers changes mid-frame have no visible effect until the next wrap.
- Digit value: d = snapshot[4*idx+3 : 4*idx].
- Segment decode: standard gfedcba encoding for 0..9. Values 10..15 show "-" (g only).
- Leading-zero blank: if LZ_BLANK and idx = 3 and d = 0, seg is all off; dp still follows dp_mask.
- Anode enable for digit idx requires all of:
  - started = 1;
  - phase <= brightness;
  - not blink-suppressed.
- Blink suppression: blink_en = 1, blink_phase = 1, and idx is in the selected field.
- Anode blanking guard: the anode is forced inactive on the final cycle of each slot (prescaler = TICK_DIV-1) to suppress ghosting. seg/dp/an outputs are registered, giving 1 cycle latency from idx/phase.
- Blink counter:
  - Counts frames on frame_start; at BLINK_FRAMES-1 it wraps and toggles blink_phase.
  - blink_en = 0 clears blink_cnt and blink_phase, so the field is visible immediately.
  - blink_sel changes take effect on the next cycle.
- Polarity: SEG_ACT_LOW and AN_ACT_LOW invert only at the output register, never internal logic.
- Brightness: sampled continuously; a change applies from the next phase boundary. brightness = 7 gives full duty minus the guard cycle.
- Reset mid-frame: immediate return to reset values at the next edge, display dark until the first tick.

Decomposition:
- Package seg_pkg holds:
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - digit index type (2-bit);
  - the bcd_to_seg decode function.
- One combinational sub-module, seg_decoder (4-bit BCD in, 7-bit active-high seg out), instantiated once on the muxed digit.
- Scan, PWM, blink and snapshot logic stay in seven_seg_scan.

Test Plan (CLK_HZ=1600, SCAN_HZ=100 -> TICK_DIV=16, phase length 2; BLINK_FRAMES=2; both polarities active-low):
- Reset and first frame: hold RST_N=0 for 5 cycles with numbers=16'h1234 -> an=4'b1111, seg=7'h7F. Release -> still dark for 16 cycles. At the tick, frame_start pulses and digit 0 shows "4" (seg=7'b0011001, an=4'b1110). Digits then cycle 1,2,3 every 16 cycles.
- Snapshot: change numbers from 16'h1234 to 16'h5678 while digit 1 is active -> digits 2 and 3 still show 2 and 1; the next frame shows 8,7,6,5.
- Leading zero and invalid BCD: numbers=16'h09A5 -> digit 3 all segments off, digit 2 "9", digit 1 "-" (g only), digit 0 "5".
- Brightness: brightness=0 -> each anode active exactly 2 cycles per slot. brightness=7 -> 15 cycles (guard cycle off).
- Blink: blink_en=1, blink_sel=1 -> digits 1,0 dark in alternate 2-frame periods; digits 3,2 never suppressed. Drop blink_en while dark -> digits 1,0 visible in the next slot.
- Reset mid-operation: assert RST_N=0 during digit 2, phase 3 -> next edge has an=4'b1111 and frame_start=0. After release, the first tick reloads the snapshot and restarts at digit 0.
